// File: rtl/otter_xtea_mmio_if.sv
// OTTER IOBUS slice seen by an MMIO peripheral: address, write data,
// write strobe from the MCU and read data back to the IOBUS_IN mux.
interface otter_xtea_mmio_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;

  modport master (
    output iobus_addr,
    output iobus_out,
    output iobus_wr,
    input  iobus_in
  );

  modport slave (
    input  iobus_addr,
    input  iobus_out,
    input  iobus_wr,
    output iobus_in
  );
endinterface

// File: rtl/otter_xtea_mmio.sv
// XTEA block-cipher accelerator on the OTTER MMIO bus. One XTEA cycle
// (two Feistel rounds) completes per clock; a level interrupt reports done.
module otter_xtea_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0400,
  parameter int unsigned NUM_CYCLES = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  otter_xtea_mmio_if.slave         bus,
  output logic                     o_xtea_irq
);

  localparam logic [31:0] DELTA        = 32'h9E37_79B9;
  localparam logic [63:0] SUM_DEC_FULL = 64'(NUM_CYCLES) * {32'h0, DELTA};
  localparam logic [31:0] SUM_DEC      = SUM_DEC_FULL[31:0];
  localparam logic [5:0]  LAST_CYCLE   = 6'(NUM_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // XTEA mixing term applied to one half of the block
  function automatic logic [31:0] mix(input logic [31:0] x);
    return ((x << 3'd4) ^ (x >> 3'd5)) + x;
  endfunction

  state_t      r_state;
  logic [31:0] r_key [4];
  logic [31:0] r_v0;
  logic [31:0] r_v1;
  logic [31:0] r_sum;
  logic [5:0]  r_cnt;
  logic        r_mode;
  logic        r_irq_en;
  logic        r_done;

  logic        w_hit;
  logic [2:0]  w_sel;
  logic        w_wr;
  logic        w_busy;
  logic [31:0] w_enc_v0;
  logic [31:0] w_enc_sum;
  logic [31:0] w_enc_v1;
  logic [31:0] w_dec_v1;
  logic [31:0] w_dec_sum;
  logic [31:0] w_dec_v0;
  logic [31:0] w_rdata;

  assign w_hit  = (bus.iobus_addr[31:5] == BASE_ADDR[31:5]);
  assign w_sel  = bus.iobus_addr[4:2];
  assign w_wr   = bus.iobus_wr & w_hit;
  assign w_busy = (r_state == S_RUN);

  // Encrypt cycle: the second round uses the v0 and sum just produced.
  assign w_enc_v0  = r_v0 + (mix(r_v1) ^ (r_sum + r_key[r_sum[1:0]]));
  assign w_enc_sum = r_sum + DELTA;
  assign w_enc_v1  = r_v1 + (mix(w_enc_v0) ^ (w_enc_sum + r_key[w_enc_sum[12:11]]));

  // Decrypt cycle: undo the rounds in reverse order.
  assign w_dec_v1  = r_v1 - (mix(r_v0) ^ (r_sum + r_key[r_sum[12:11]]));
  assign w_dec_sum = r_sum - DELTA;
  assign w_dec_v0  = r_v0 - (mix(w_dec_v1) ^ (w_dec_sum + r_key[w_dec_sum[1:0]]));

  assign o_xtea_irq   = r_done & r_irq_en;
  assign bus.iobus_in = w_rdata;

  // Register file, IDLE/RUN sequencing and the cipher datapath
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      for (int i = 0; i < 4; i++) begin
        r_key[i] <= 32'h0;
      end
      r_v0     <= 32'h0;
      r_v1     <= 32'h0;
      r_sum    <= 32'h0;
      r_cnt    <= 6'd0;
      r_mode   <= 1'b0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Done clear is honoured in any state; completion below overrides it.
      if (w_wr && (w_sel == 3'd7) && bus.iobus_out[1]) begin
        r_done <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_wr) begin
            case (w_sel)
              3'd0, 3'd1, 3'd2, 3'd3: r_key[w_sel[1:0]] <= bus.iobus_out;
              3'd4: r_v0 <= bus.iobus_out;
              3'd5: r_v1 <= bus.iobus_out;
              3'd6: begin
                r_mode   <= bus.iobus_out[1];
                r_irq_en <= bus.iobus_out[2];
                if (bus.iobus_out[0]) begin
                  r_state <= S_RUN;
                  r_done  <= 1'b0;
                  r_cnt   <= 6'd0;
                  r_sum   <= bus.iobus_out[1] ? SUM_DEC : 32'h0;
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (r_mode) begin
            r_v0  <= w_dec_v0;
            r_v1  <= w_dec_v1;
            r_sum <= w_dec_sum;
          end else begin
            r_v0  <= w_enc_v0;
            r_v1  <= w_enc_v1;
            r_sum <= w_enc_sum;
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_CYCLE) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-data mux; keys and the start bit read back as zero
  always_comb begin
    w_rdata = 32'h0;
    if (w_hit) begin
      case (w_sel)
        3'd4:    w_rdata = r_v0;
        3'd5:    w_rdata = r_v1;
        3'd6:    w_rdata = {29'h0, r_irq_en, r_mode, 1'b0};
        3'd7:    w_rdata = {30'h0, r_done, w_busy};
        default: w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = 32'h0;
    end
  end

endmodule

// File: tb/tb_otter_xtea_mmio.sv
// Directed bench for otter_xtea_mmio: expected blocks are queued when a
// run is started and compared against DATA0/DATA1 when done is seen.
module tb_otter_xtea_mmio;

  localparam logic [31:0] BASE = 32'h1100_0400;
  localparam logic [31:0] KEY0 = BASE + 32'h00;
  localparam logic [31:0] KEY1 = BASE + 32'h04;
  localparam logic [31:0] KEY2 = BASE + 32'h08;
  localparam logic [31:0] KEY3 = BASE + 32'h0C;
  localparam logic [31:0] DAT0 = BASE + 32'h10;
  localparam logic [31:0] DAT1 = BASE + 32'h14;
  localparam logic [31:0] CTRL = BASE + 32'h18;
  localparam logic [31:0] STAT = BASE + 32'h1C;
  localparam int NUMC = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   cyc = 0;
  int   t0 = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  logic [31:0] tk [4];
  logic [63:0] exp_q [$];

  otter_xtea_mmio_if bus ();

  otter_xtea_mmio #(.BASE_ADDR(BASE), .NUM_CYCLES(NUMC)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .bus        (bus.slave),
    .o_xtea_irq (irq)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure latency from a start write
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model_enc(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] s;
    y = a;
    z = b;
    s = 32'h0;
    for (int i = 0; i < NUMC; i++) begin
      y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + tk[s[1:0]]));
      s = s + 32'h9E3779B9;
      z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + tk[s[12:11]]));
    end
    return {y, z};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic wr_now(input logic [31:0] a, input logic [31:0] d);
    bus.iobus_addr = a;
    bus.iobus_out  = d;
    bus.iobus_wr   = 1'b1;
    @(posedge clk);
    #1;
    bus.iobus_wr   = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_now(a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.iobus_addr = a;
    #1;
    d = bus.iobus_in;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic load(input logic [31:0] k0, input logic [31:0] k1, input logic [31:0] k2,
                      input logic [31:0] k3, input logic [31:0] d0, input logic [31:0] d1);
    tk[0] = k0; tk[1] = k1; tk[2] = k2; tk[3] = k3;
    wr(KEY0, k0); wr(KEY1, k1); wr(KEY2, k2); wr(KEY3, k3);
    wr(DAT0, d0); wr(DAT1, d1);
  endtask

  task automatic start(input logic [31:0] c);
    wr(CTRL, c);
    t0 = cyc;
  endtask

  task automatic start_now(input logic [31:0] c);
    wr_now(CTRL, c);
    t0 = cyc;
  endtask

  task automatic check_data(input string tag);
    logic [63:0] e;
    logic [31:0] d0;
    logic [31:0] d1;
    check({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      rd(DAT0, d0);
      check({tag, "_data0"}, d0, e[63:32]);
      rd(DAT1, d1);
      check({tag, "_data1"}, d1, e[31:0]);
    end
  endtask

  // Poll STATUS once per cycle until done; latency -1 marks a timeout.
  task automatic finish_run(input string tag, input logic exp_irq);
    logic [31:0] s;
    int   lat;
    logic irq_seen;
    lat = -1;
    irq_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      rd(STAT, s);
      if (s[1]) begin
        lat = cyc - t0;
        irq_seen = irq;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(NUMC));
    check({tag, "_irq_at_done"}, {31'd0, irq_seen}, {31'd0, exp_irq});
    check_data(tag);
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] r1;
    bus.iobus_addr = 32'h0;
    bus.iobus_out  = 32'h0;
    bus.iobus_wr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk_reg("rst_status", STAT, 32'h0);
    chk_reg("rst_data0", DAT0, 32'h0);
    chk_reg("rst_data1", DAT1, 32'h0);
    chk_reg("rst_ctrl", CTRL, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Known encrypt vector
    load(32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 32'h41424344, 32'h45464748);
    chk_reg("key_reads_zero", KEY1, 32'h0);
    start(32'h1);
    exp_q.push_back(64'h497DF3D0_72612CB5);
    chk_reg("enc_busy", STAT, 32'h1);
    finish_run("enc", 1'b0);

    // Decrypt started on the edge right after done (result is already in DATA)
    start_now(32'h3);
    exp_q.push_back(64'h41424344_45464748);
    chk_reg("b2b_busy_done_clr", STAT, 32'h1);
    finish_run("dec", 1'b0);
    chk_reg("dec_status", STAT, 32'h2);
    chk_reg("dec_ctrl", CTRL, 32'h2);

    // All-zero vector
    load(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    start(32'h1);
    exp_q.push_back(64'hDEE9D4D8_F7131ED9);
    finish_run("zero", 1'b0);

    // Writes while busy are ignored, completion time unchanged
    load(32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 32'h41424344, 32'h45464748);
    start(32'h1);
    exp_q.push_back(64'h497DF3D0_72612CB5);
    wr(DAT0, 32'hFFFFFFFF);
    wr(KEY0, 32'h0);
    wr(CTRL, 32'h7);
    finish_run("busy_prot", 1'b0);
    chk_reg("busy_prot_ctrl", CTRL, 32'h0);
    chk_reg("busy_prot_status", STAT, 32'h2);

    // Interrupt at done, cleared by STATUS write-1
    wr(DAT0, 32'h41424344);
    wr(DAT1, 32'h45464748);
    start(32'h5);
    exp_q.push_back(64'h497DF3D0_72612CB5);
    finish_run("irq", 1'b1);
    chk_reg("irq_ctrl", CTRL, 32'h4);
    wr(STAT, 32'h2);
    chk_reg("w1c_status", STAT, 32'h0);
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // W1C on the completing edge: completion wins
    wr(DAT0, 32'h41424344);
    wr(DAT1, 32'h45464748);
    start(32'h5);
    exp_q.push_back(64'h497DF3D0_72612CB5);
    while (cyc < t0 + NUMC - 1) begin
      @(posedge clk);
      #1;
    end
    wr_now(STAT, 32'h2);
    chk_reg("w1c_race_status", STAT, 32'h2);
    check("w1c_race_irq", {31'd0, irq}, 32'd1);
    check_data("w1c_race");

    // New start drops the interrupt, then reset mid-run
    start(32'h5);
    check("restart_irq", {31'd0, irq}, 32'd0);
    chk_reg("restart_busy", STAT, 32'h1);
    while (cyc < t0 + 10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reg("midrst_status", STAT, 32'h0);
    chk_reg("midrst_data0", DAT0, 32'h0);
    chk_reg("midrst_data1", DAT1, 32'h0);
    chk_reg("midrst_ctrl", CTRL, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'd0);

    // Address decode: low bits ignored, misses read zero and do not write
    wr(BASE + 32'h12, 32'h12345678);
    chk_reg("dec_low_bits", DAT0, 32'h12345678);
    chk_reg("dec_miss_above", BASE + 32'h20, 32'h0);
    chk_reg("dec_alias_above", BASE + 32'h30, 32'h0);
    chk_reg("dec_alias_below", BASE - 32'h10, 32'h0);
    chk_reg("dec_miss_below", BASE - 32'h4, 32'h0);
    wr(BASE + 32'h30, 32'hCAFEF00D);
    wr(BASE - 32'h10, 32'hCAFEF00D);
    chk_reg("dec_miss_no_write", DAT0, 32'h12345678);

    // Random key/data against the bench model, then decrypt back-to-back
    r0 = $urandom;
    r1 = $urandom;
    load($urandom, $urandom, $urandom, $urandom, r0, r1);
    start(32'h1);
    exp_q.push_back(model_enc(r0, r1));
    finish_run("rand_enc", 1'b0);
    start_now(32'h3);
    exp_q.push_back({r0, r1});
    finish_run("rand_dec", 1'b0);
    chk_reg("rand_status", STAT, 32'h2);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
